// File: rtl/tiny_fpga_b.sv
// tiny_fpga_b: TinyFPGA-B style LED demo.
// A free-running counter drives the LED either as a plain blink (one counter
// bit) or as a "breathing" PWM whose duty follows a triangle wave taken from
// the counter's upper bits. The USB pins are held low so no host enumerates us.
module tiny_fpga_b #(
    parameter int CNT_WIDTH = 24,
    parameter int LED_BIT   = 23,
    parameter int MODE      = 0,
    parameter int PWM_BITS  = 8
) (
    input  logic pin3_clk_16mhz,
    input  logic pin4_reset,
    output logic pin1_usb_dp,
    output logic pin2_usb_dn,
    output logic pin13
);

    // Reset-release synchronizer; run goes high on the 2nd edge after release.
    logic [1:0]           sync;
    logic                 run;
    logic [CNT_WIDTH-1:0] cnt;

    assign pin1_usb_dp = 1'b0;
    assign pin2_usb_dn = 1'b0;
    assign run         = sync[1];

    // Shift ones into the synchronizer once reset is released.
    always_ff @(posedge pin3_clk_16mhz or negedge pin4_reset) begin
        if (!pin4_reset) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], 1'b1};
        end
    end

    // Free-running counter, wraps silently modulo 2^CNT_WIDTH.
    always_ff @(posedge pin3_clk_16mhz or negedge pin4_reset) begin
        if (!pin4_reset) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 1'b1;
        end
    end

    generate
        if (MODE == 0) begin : g_blink
            // A single flop bit straight to the pin keeps the LED glitch-free.
            assign pin13 = cnt[LED_BIT];
        end else begin : g_breathe
            logic [PWM_BITS-1:0] ramp;
            logic [PWM_BITS-1:0] bright;
            logic                led_q;

            // Mirror the ramp on the upper half of the count for a triangle wave.
            assign ramp   = cnt[CNT_WIDTH-2 -: PWM_BITS];
            assign bright = cnt[CNT_WIDTH-1] ? ~ramp : ramp;
            assign pin13  = led_q;

            // Registered PWM compare of the low counter bits against brightness.
            always_ff @(posedge pin3_clk_16mhz or negedge pin4_reset) begin
                if (!pin4_reset) begin
                    led_q <= 1'b0;
                end else if (run) begin
                    led_q <= (cnt[PWM_BITS-1:0] < bright);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_tiny_fpga_b.sv
// tb_tiny_fpga_b: checks three builds of tiny_fpga_b (4-bit blink, 9-bit
// breathe, defaults) against a model driven by the number of clock edges
// seen since reset release.
`timescale 1ns/100ps
module tb_tiny_fpga_b;

    logic clk   = 1'b1;
    logic rst_n = 1'b1;

    logic blink_dp, blink_dn, blink_led;
    logic pwm_dp, pwm_dn, pwm_led;
    logic def_dp, def_dn, def_led;

    int tests_run    = 0;
    int tests_failed = 0;
    bit mon_en       = 1'b1;
    bit collect      = 1'b1;
    int edges;
    int frame_high [32];

    typedef struct {
        int   edge_n;
        int   exp_cnt;
        logic exp_led;
    } vec_t;

    vec_t vecs [12];

    tiny_fpga_b #(.CNT_WIDTH(4), .LED_BIT(3), .MODE(0), .PWM_BITS(8)) dut_blink (
        .pin3_clk_16mhz(clk), .pin4_reset(rst_n),
        .pin1_usb_dp(blink_dp), .pin2_usb_dn(blink_dn), .pin13(blink_led));

    tiny_fpga_b #(.CNT_WIDTH(9), .LED_BIT(8), .MODE(1), .PWM_BITS(4)) dut_pwm (
        .pin3_clk_16mhz(clk), .pin4_reset(rst_n),
        .pin1_usb_dp(pwm_dp), .pin2_usb_dn(pwm_dn), .pin13(pwm_led));

    tiny_fpga_b dut_def (
        .pin3_clk_16mhz(clk), .pin4_reset(rst_n),
        .pin1_usb_dp(def_dp), .pin2_usb_dn(def_dn), .pin13(def_led));

    // 2 ns clock, rising edges at 2, 4, 6 ...
    always #1 clk = ~clk;

    // Number of rising edges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    // Counter value after edge e: idle for two edges, then 1, 2, 3 ... wrapping.
    function automatic int model_cnt(input int e, input int w);
        if (e < 3) return 0;
        return (e - 2) % (1 << w);
    endfunction

    // Breathe LED after edge e reflects the count held before that edge.
    function automatic int model_pwm(input int e);
        int c, r, b;
        if (e < 3) return 0;
        c = (e - 3) % 512;
        r = (c / 16) % 16;
        b = (c >= 256) ? (15 - r) : r;
        return ((c % 16) < b) ? 1 : 0;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_cleared(input string tag);
        check_output({tag, "_blink_cnt"}, 32'(dut_blink.cnt), 0);
        check_output({tag, "_blink_led"}, 32'(blink_led), 0);
        check_output({tag, "_pwm_cnt"}, 32'(dut_pwm.cnt), 0);
        check_output({tag, "_pwm_led"}, 32'(pwm_led), 0);
        check_output({tag, "_def_cnt"}, 32'(dut_def.cnt), 0);
        check_output({tag, "_usb"}, 32'({blink_dp, blink_dn, pwm_dp, pwm_dn, def_dp, def_dn}), 0);
    endtask

    // Pulse reset low starting 0.3 ns after a rising edge; short pulses end before the next edge.
    task automatic apply_stimulus(input bit short_pulse, input int len);
        @(posedge clk);
        #0.3;
        rst_n = 1'b0;
        #0.5;
        check_cleared("reset_mid");
        if (short_pulse) begin
            #0.5;
        end else begin
            repeat (len) @(posedge clk);
            #0.2;
        end
        rst_n = 1'b1;
    endtask

    // Compare every build against the model on each falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check_output("blink_cnt", 32'(dut_blink.cnt), model_cnt(edges, 4));
            check_output("blink_led", 32'(blink_led), (model_cnt(edges, 4) >> 3) & 1);
            check_output("pwm_cnt", 32'(dut_pwm.cnt), model_cnt(edges, 9));
            check_output("pwm_led", 32'(pwm_led), model_pwm(edges));
            check_output("def_cnt", 32'(dut_def.cnt), model_cnt(edges, 24));
            check_output("def_led", 32'(def_led), (model_cnt(edges, 24) >> 23) & 1);
            check_output("usb_pins", 32'({blink_dp, blink_dn, pwm_dp, pwm_dn, def_dp, def_dn}), 0);
            if (collect && edges >= 3 && edges <= 514)
                frame_high[(edges - 3) / 16] += int'(pwm_led);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int guard;
        vecs[0]  = '{1, 0, 1'b0};
        vecs[1]  = '{2, 0, 1'b0};
        vecs[2]  = '{3, 1, 1'b0};
        vecs[3]  = '{4, 2, 1'b0};
        vecs[4]  = '{9, 7, 1'b0};
        vecs[5]  = '{10, 8, 1'b1};
        vecs[6]  = '{17, 15, 1'b1};
        vecs[7]  = '{18, 0, 1'b0};
        vecs[8]  = '{19, 1, 1'b0};
        vecs[9]  = '{22, 4, 1'b0};
        vecs[10] = '{26, 8, 1'b1};
        vecs[11] = '{34, 0, 1'b0};

        rst_n = 1'b0;
        #3;
        check_cleared("in_reset");
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            guard = 0;
            while (edges < vecs[i].edge_n && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check_output($sformatf("table%0d_edge", i), 32'(edges), 32'(vecs[i].edge_n));
            check_output($sformatf("table%0d_cnt", i), 32'(dut_blink.cnt), 32'(vecs[i].exp_cnt));
            check_output($sformatf("table%0d_led", i), 32'(blink_led), 32'(vecs[i].exp_led));
        end

        guard = 0;
        while (edges < 520 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        collect = 1'b0;
        check_output("frame00_high", 32'(frame_high[0]), 0);
        check_output("frame01_high", 32'(frame_high[1]), 1);
        check_output("frame03_high", 32'(frame_high[3]), 3);
        check_output("frame15_high", 32'(frame_high[15]), 15);
        check_output("frame16_high", 32'(frame_high[16]), 15);
        check_output("frame28_high", 32'(frame_high[28]), 3);
        check_output("frame31_high", 32'(frame_high[31]), 0);

        guard = 0;
        while (model_cnt(edges, 4) != 10 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #0.3;
        check_output("midrun_cnt_before", 32'(dut_blink.cnt), 11);
        check_output("midrun_led_before", 32'(blink_led), 1);
        rst_n = 1'b0;
        #0.5;
        check_cleared("midrun");
        #0.5;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #0.5;
        check_output("restart_edge2_cnt", 32'(dut_blink.cnt), 0);
        @(posedge clk);
        #0.5;
        check_output("restart_edge3_cnt", 32'(dut_blink.cnt), 1);

        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(3, 300)) @(negedge clk);
            apply_stimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 4)));
        end

        repeat (40) @(negedge clk);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tiny_fpga_b.md
TINY_FPGA_B -- requirements
Module: tiny_fpga_b

Interface
REQ-001 Parameter CNT_WIDTH, default 24: width of the free-running counter; legal range 4..32.
REQ-002 Parameter LED_BIT, default 23: counter bit driven to the LED in blink mode; legal range 0..CNT_WIDTH-1.
REQ-003 Parameter MODE, default 0: LED mode; 0 = blink, 1 = breathe (PWM).
REQ-004 Parameter PWM_BITS, default 8: PWM resolution in breathe mode; MODE=1 requires CNT_WIDTH >= 2*PWM_BITS+1.
REQ-005 pin3_clk_16mhz  input  1  sole clock; all flops on its rising edge; nominal 16 MHz.
REQ-006 pin4_reset  input  1  reset; asynchronous, active-low (0 = reset).
REQ-007 pin1_usb_dp  output  1  USB D+; constant 0.
REQ-008 pin2_usb_dn  output  1  USB D-; constant 0.
REQ-009 pin13  output  1  LED drive; 1 = LED on.

Function
REQ-010 pin1_usb_dp and pin2_usb_dn SHALL be tied to 0 at all times, including during reset, so the USB host does not detect a device.
REQ-011 Reset release SHALL pass through a 2-flop synchronizer: both stages cleared asynchronously by pin4_reset=0; after release, stage 0 loads 1 at the 1st rising edge and stage 1 at the 2nd; internal run enable = stage 1.
REQ-012 cnt (CNT_WIDTH bits) SHALL hold 0 while run enable is 0, then increment by 1 at every rising edge; the first increment (0->1) occurs at the 3rd rising edge after pin4_reset goes high.
REQ-013 cnt SHALL wrap modulo 2^CNT_WIDTH (all-ones -> 0) with no flag, stall or carry-out.
REQ-014 MODE=0: pin13 SHALL equal cnt[LED_BIT] directly (single flop bit, glitch-free); LED period = 2^(LED_BIT+1) clocks with 50% duty. Defaults give ~1.05 s period at 16 MHz.
REQ-015 MODE=1: ramp r = cnt[CNT_WIDTH-2 -: PWM_BITS]; brightness b = cnt[CNT_WIDTH-1] ? ~r : r (triangle wave).
REQ-016 MODE=1: pin13 SHALL be a register loaded each enabled edge with (cnt[PWM_BITS-1:0] < b), unsigned compare, computed from the pre-edge cnt; one clock of latency.
REQ-017 MODE=1 boundaries: b=0 -> pin13 constantly 0 over the whole PWM frame; b=2^PWM_BITS-1 -> pin13 high for 2^PWM_BITS-1 of the 2^PWM_BITS frame clocks.
REQ-018 The block SHALL contain no other state, no latches and no combinational path from pin4_reset to pin13 other than the asynchronous clear.

Reset
REQ-019 pin4_reset=0 SHALL immediately (no clock required) clear cnt, both synchronizer stages and the pin13 register; pin13 reads 0 during reset in both modes.
REQ-020 Reset asserted mid-count SHALL abort the count; after release, counting restarts from 0 with the timing of REQ-012.
REQ-021 A reset pulse shorter than one clock period SHALL still fully clear all state.

Verification
REQ-022 USB pins: any stimulus, including reset and free-run -> pin1_usb_dp = pin2_usb_dn = 0 at every sample.
REQ-023 Reset/start-up: pin4_reset=0 for 5 ns, then 1, clock period 2 ns -> pin13=0 and cnt=0 during reset; cnt=1 after 3rd rising edge post-release, then +1 per edge.
REQ-024 Blink (CNT_WIDTH=4, LED_BIT=3) -> pin13 rises when cnt goes 7->8 and falls when cnt goes 15->0; repeated period 16 clocks.
REQ-025 Wrap: CNT_WIDTH=4, run 20 increments -> cnt sequence ...14, 15, 0, 1, 2, 3, 4 with no disturbance.
REQ-026 Mid-run reset: pulse pin4_reset=0 for 1 ns while cnt=11 -> cnt and pin13 go to 0 without a clock edge; restart per REQ-012.
REQ-027 Breathe (MODE=1, CNT_WIDTH=9, PWM_BITS=4): cnt[8:4]=5'b00011 -> pin13 high for 3 of 16 frame clocks; cnt[8:4]=5'b11100 -> high 3 of 16; cnt[8:4]=5'b00000 -> always 0.
